// File: rtl/uart_pkg.sv
// uart_pkg: shared UART encodings -- receiver states, parity-select codes, error bit indices.
// Used by both uart_rx and uart_tx so the cfg_* encoding stays identical on both paths.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_BIT,
        ST_DATA,
        ST_PARITY,
        ST_STOP_FIRST,
        ST_STOP_LAST
    } uart_state_e;

    localparam logic [1:0] PAR_ODD  = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ZERO = 2'b10;
    localparam logic [1:0] PAR_ONE  = 2'b11;

    localparam int ERR_PE = 0;
    localparam int ERR_FE = 1;
    localparam int ERR_OE = 2;

    // Expected parity bit given the XOR of all data bits.
    function automatic logic exp_parity(input logic [1:0] sel, input logic data_xor);
        return (sel == PAR_ODD)  ? ~data_xor :
               (sel == PAR_EVEN) ?  data_xor :
               (sel == PAR_ZERO) ?  1'b0     : 1'b1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-data holding register and error reporting towards the APB register file.
//   rx_data   8  received byte, right-aligned
//   rx_valid  1  rx_data holds an unread byte
//   rx_ready  1  consumer accepts the byte when rx_valid & rx_ready
//   err       3  sticky {overrun, framing, parity}
//   err_clr   1  clears err on the next cycle
// master = receiver side, slave = consumer side.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] err;
    logic       err_clr;

    modport master (output rx_data, rx_valid, err, input rx_ready, err_clr);
    modport slave  (input rx_data, rx_valid, err, output rx_ready, err_clr);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: SYNC_STAGES-deep synchroniser for the async rx line plus a falling-edge detect.
//   clk_i, rstn_i  clock, asynchronous active-low reset
//   rx_i           raw serial line (idle high)
//   rx_s           synchronised line
//   fall           rx_s went 1->0 this cycle
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic rx_i,
    output logic rx_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Flops reset to 1 so an idle line never looks like a start edge after reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = prev_q & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver -- start, 5-8 data bits LSB-first, optional parity, 1-2 stop bits.
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   rx_i               serial line, async, idle high
//   cfg_en_i           receiver enable
//   cfg_div_i          bit period = cfg_div_i+1 clocks
//   cfg_parity_en_i    parity bit present
//   cfg_parity_sel_i   00 odd, 01 even, 10 zero, 11 one
//   cfg_bits_i         data bits = cfg_bits_i+5
//   cfg_stop_bits_i    0: one stop bit, 1: two
//   busy_o             frame in progress
//   rx_if              holding register / sticky errors (uart_rx_if.master)
// Build option: define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 majority around the
// sample point (needs cfg_div_i >= 4); otherwise the single sample at the sample point is used.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        rx_i,
    input  logic        cfg_en_i,
    input  logic [15:0] cfg_div_i,
    input  logic        cfg_parity_en_i,
    input  logic [1:0]  cfg_parity_sel_i,
    input  logic [1:0]  cfg_bits_i,
    input  logic        cfg_stop_bits_i,
    output logic        busy_o,
    uart_rx_if.master   rx_if
);

    uart_state_e state_q, state_d;
    logic [15:0] cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shreg_q;
    logic        par_q, pe_q, fe_q;
    logic        rx_s, rx_fall, rx_d, bit_val;
    logic        tick, last_bit, in_stop, commit, fe_now, good, accept;
    logic [2:0]  new_err;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
        .rx_i  (rx_i),
        .rx_s  (rx_s),
        .fall  (rx_fall)
    );

    // Bits are judged one cycle late (rx_d) in both builds so the majority window can include
    // the sample after the sample point while keeping the same frame latency.
`ifdef UART_RX_MAJORITY_EN
    logic rx_d2;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_d  <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d  <= rx_s;
            rx_d2 <= rx_d;
        end
    end
    assign bit_val = (rx_s & rx_d) | (rx_s & rx_d2) | (rx_d & rx_d2);
`else
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) rx_d <= 1'b1;
        else         rx_d <= rx_s;
    end
    assign bit_val = rx_d;
`endif

    assign tick     = cnt_q == (cfg_div_i >> 1);
    assign last_bit = bit_cnt_q == ({1'b0, cfg_bits_i} + 3'd4);
    assign in_stop  = (state_q == ST_STOP_FIRST) || (state_q == ST_STOP_LAST);
    assign fe_now   = fe_q | (in_stop & tick & ~bit_val);
    // Commit fires at the final stop sample, half a bit early, so a following start edge is seen.
    assign commit   = cfg_en_i & tick &
                      ((state_q == ST_STOP_LAST) || (state_q == ST_STOP_FIRST && !cfg_stop_bits_i));
    assign good     = commit & ~pe_q & ~fe_now;
    assign accept   = rx_if.rx_valid & rx_if.rx_ready;
    assign busy_o   = state_q != ST_IDLE;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       state_d = rx_fall ? ST_START_BIT : ST_IDLE;
            ST_START_BIT:  state_d = !tick ? ST_START_BIT : bit_val ? ST_IDLE : ST_DATA;
            ST_DATA:       state_d = !(tick && last_bit) ? ST_DATA :
                                     cfg_parity_en_i ? ST_PARITY : ST_STOP_FIRST;
            ST_PARITY:     state_d = tick ? ST_STOP_FIRST : ST_PARITY;
            ST_STOP_FIRST: state_d = !tick ? ST_STOP_FIRST : cfg_stop_bits_i ? ST_STOP_LAST : ST_IDLE;
            ST_STOP_LAST:  state_d = tick ? ST_IDLE : ST_STOP_LAST;
            default:       state_d = ST_IDLE;
        endcase
        if (!cfg_en_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else if (!cfg_en_i) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
        end else begin
            cnt_q <= (state_q == ST_IDLE || cnt_q == cfg_div_i) ? 16'd0 : cnt_q + 16'd1;
            if (tick) begin
                case (state_q)
                    ST_START_BIT: begin
                        bit_cnt_q <= '0;
                        shreg_q   <= '0;
                        par_q     <= 1'b0;
                        pe_q      <= 1'b0;
                        fe_q      <= 1'b0;
                    end
                    ST_DATA: begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        shreg_q   <= {bit_val, shreg_q[7:1]};
                        par_q     <= par_q ^ bit_val;
                    end
                    ST_PARITY:     pe_q <= bit_val != exp_parity(cfg_parity_sel_i, par_q);
                    ST_STOP_FIRST: fe_q <= fe_now;
                    ST_STOP_LAST:  fe_q <= fe_now;
                    default:       ;
                endcase
            end
        end
    end

    always_comb begin
        new_err         = '0;
        new_err[ERR_PE] = commit & pe_q;
        new_err[ERR_FE] = commit & fe_now;
        new_err[ERR_OE] = good & rx_if.rx_valid & ~accept;
    end

    // Holding register and sticky errors survive cfg_en_i low; only reset clears them.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_if.rx_data  <= '0;
            rx_if.rx_valid <= 1'b0;
            rx_if.err      <= '0;
        end else begin
            if (good && (!rx_if.rx_valid || accept)) begin
                rx_if.rx_data  <= shreg_q >> (2'd3 - cfg_bits_i);
                rx_if.rx_valid <= 1'b1;
            end else if (accept) begin
                rx_if.rx_valid <= 1'b0;
            end
            rx_if.err <= (rx_if.err_clr ? 3'b000 : rx_if.err) | new_err;
        end
    end

endmodule
